cs_mir_seq: RTL and testbench
=============================

Name: cs_mir_seq

Overview:
- Parametrised microinstruction register for the control-store datapath, with generic field widths.
- Adds a synchronous load enable, a synchronous clear that forces a NOP, and a memory-wait sequencer that holds any RD/WR microinstruction for a programmable number of extra cycles while asserting stall back to the microsequencer.
- Also provides a saturating issued-microinstruction counter for bring-up and performance debug.

Parameters:
- MIR_LENGTH_Reg, 6, width of A/B/C register-select fields.
- MIR_LENGTH_ALU, 4, width of ALU function field.
- MIR_LENGTH_COND, 3, width of branch-condition field.
- MIR_LENGTH_ADDR, 11, width of next-address field.
- MIR_MEM_WAIT, 2, extra hold cycles for RD/WR microinstructions. Legal range 0..15; 0 means no wait.
- MIR_LENGTH_CNT, 16, width of issued counter.
- MIR_LENGTH_INSTR (localparam) = 3*MIR_LENGTH_Reg + 5 + MIR_LENGTH_ALU + MIR_LENGTH_COND + MIR_LENGTH_ADDR. Default value 41.

Ports:
- CS_MIR_CLOCK_50  in  1  system clock, rising edge.
- CS_MIR_RESET_InHigh  in  1  asynchronous, active-high reset.
- CS_MIR_clear_InLow  in  1  synchronous clear, active-low.
- CS_MIR_load_InLow  in  1  synchronous load enable, active-low.
- CS_MIR_INSTRUCTION_data_InBUS  in  MIR_LENGTH_INSTR  microinstruction from control store.
- CS_MIR_A_data_OutBUS / CS_MIR_B_data_OutBUS / CS_MIR_C_data_OutBUS  out  MIR_LENGTH_Reg  register selects.
- CS_MIR_AMUX_data_Out / CS_MIR_BMUX_data_Out / CS_MIR_CMUX_data_Out  out  1  mux selects.
- CS_MIR_RD_data_Out / CS_MIR_WR_data_Out  out  1  memory read / write.
- CS_MIR_ALU_data_OutBUS  out  MIR_LENGTH_ALU  ALU function.
- CS_MIR_COND_data_OutBUS  out  MIR_LENGTH_COND  branch condition.
- CS_MIR_ADDRESS_data_OutBUS  out  MIR_LENGTH_ADDR  next address.
- CS_MIR_VALID_Out  out  1  register holds a loaded, non-cleared microinstruction.
- CS_MIR_STALL_Out  out  1  memory wait in progress; microsequencer must hold its MPC.
- CS_MIR_ISSUED_COUNT_OutBUS  out  MIR_LENGTH_CNT  accepted loads, saturating.

Behaviour:
- Field packing, MSB to LSB: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, ADDR. At defaults: A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20], RD[19], WR[18], ALU[17:14], COND[13:11], ADDR[10:0].
- All field outputs are direct combinational slices of the register. Latency from input to output is 1 clock.
- Reset (async, high):
  - register = 0; state = IDLE; wait counter = 0; issued counter = 0.
  - All outputs 0, including VALID and STALL.
- FSM states: IDLE, EXEC, WAIT.
  - STALL_Out = (state == WAIT), registered.
  - VALID_Out = (state != IDLE).
- Priority at each rising edge: reset > clear > stall > load.
- clear_InLow = 0:
  - register <= 0; state <= IDLE; wait counter <= 0.
  - Any in-progress wait is aborted; load is ignored.
  - Issued counter is unchanged.
- Accept condition: load_InLow = 0, clear_InLow = 1, and state != WAIT. On accept:
  - register <= instruction; issued counter increments, saturating at all-ones.
  - If the accepted RD or WR bit is 1 and MIR_MEM_WAIT > 0: state <= WAIT, wait counter <= MIR_MEM_WAIT.
  - Otherwise: state <= EXEC.
- load_InLow = 1 in IDLE or EXEC: register and state hold.
- In WAIT:
  - Register holds; loads are ignored and not counted.
  - Counter decrements each edge. At the edge where counter == 1, state <= EXEC and counter <= 0.
  - Net effect: STALL is high for exactly MIR_MEM_WAIT cycles after the load edge, and an RD/WR microinstruction is visible for MIR_MEM_WAIT+1 cycles minimum.
- Back-to-back RD/WR instructions: a new load is accepted on the first edge with STALL low, and may immediately re-enter WAIT.
- RD and WR both set: treated as a single memory access with one wait period.
- MIR_MEM_WAIT = 0: WAIT is unreachable and STALL stays 0.
- Reset asserted mid-WAIT: immediate return to reset values, with no completion cycle.

Test Plan:
1. Reset, then load instruction {6'd33,1,6'd18,0,6'd7,1,0,0,4'hA,3'd5,11'h3FF} with load_InLow=0 -> next cycle A=33, AMUX=1, B=18, BMUX=0, C=7, CMUX=1, RD=0, WR=0, ALU=4'hA, COND=5, ADDR=11'h3FF, VALID=1, STALL=0, count=1.
2. MIR_MEM_WAIT=2: load instruction with bit19 (RD) set, then present a second instruction with load held low -> STALL=1 for 2 cycles, RD=1 for 3 cycles, second instruction appears on cycle 4, count=2.
3. Hold load_InLow=1 for 5 cycles after a load -> outputs unchanged; count unchanged.
4. Mid-WAIT (STALL=1), drive clear_InLow=0 for 1 cycle -> next cycle all fields 0, VALID=0, STALL=0; a load on the following edge is accepted normally.
5. Assert CS_MIR_RESET_InHigh asynchronously between clock edges during WAIT -> all outputs 0 immediately, count=0.
6. MIR_LENGTH_CNT=4: perform 17 accepted loads -> count saturates at 4'hF; also set MIR_MEM_WAIT=0 with a WR instruction -> STALL never asserts.

Source files
------------

// File: rtl/cs_mir_seq.sv
// -----------------------------------------------------------------------------
// cs_mir_seq -- microinstruction register with memory-wait sequencer
//
// Purpose:
//   Holds the current microinstruction for the control-store datapath and
//   slices it into its fields. A microinstruction with RD or WR set is held
//   for MIR_MEM_WAIT extra cycles while STALL tells the microsequencer to
//   freeze its MPC. A saturating counter tracks accepted loads.
//
// Ports:
//   CS_MIR_CLOCK_50                in   system clock, rising edge
//   CS_MIR_RESET_InHigh            in   asynchronous reset, active high
//   CS_MIR_clear_InLow             in   synchronous clear (forces NOP), active low
//   CS_MIR_load_InLow              in   synchronous load enable, active low
//   CS_MIR_INSTRUCTION_data_InBUS  in   microinstruction from control store
//   CS_MIR_{A,B,C}_data_OutBUS     out  register-select fields
//   CS_MIR_{A,B,C}MUX_data_Out     out  mux-select bits
//   CS_MIR_RD_data_Out / WR        out  memory read / write bits
//   CS_MIR_ALU_data_OutBUS         out  ALU function field
//   CS_MIR_COND_data_OutBUS        out  branch-condition field
//   CS_MIR_ADDRESS_data_OutBUS     out  next-address field
//   CS_MIR_VALID_Out               out  register holds a live microinstruction
//   CS_MIR_STALL_Out               out  memory wait in progress
//   CS_MIR_ISSUED_COUNT_OutBUS     out  accepted loads, saturating
//   o_state                        out  FSM state (0 IDLE, 1 EXEC, 2 WAIT)
//
// Handshake: a microinstruction is accepted on a rising edge when
//   load_InLow = 0, clear_InLow = 1 and the FSM is not in WAIT. While STALL
//   is high, loads are ignored and the presenter must keep its instruction
//   steady; the first edge with STALL low accepts it.
// -----------------------------------------------------------------------------
module cs_mir_seq #(
  parameter int MIR_LENGTH_Reg  = 6,
  parameter int MIR_LENGTH_ALU  = 4,
  parameter int MIR_LENGTH_COND = 3,
  parameter int MIR_LENGTH_ADDR = 11,
  parameter int MIR_MEM_WAIT    = 2,
  parameter int MIR_LENGTH_CNT  = 16,
  localparam int MIR_LENGTH_INSTR = 3*MIR_LENGTH_Reg + 5 + MIR_LENGTH_ALU
                                    + MIR_LENGTH_COND + MIR_LENGTH_ADDR
) (
  input  logic                        CS_MIR_CLOCK_50,
  input  logic                        CS_MIR_RESET_InHigh,
  input  logic                        CS_MIR_clear_InLow,
  input  logic                        CS_MIR_load_InLow,
  input  logic [MIR_LENGTH_INSTR-1:0] CS_MIR_INSTRUCTION_data_InBUS,
  output logic [MIR_LENGTH_Reg-1:0]   CS_MIR_A_data_OutBUS,
  output logic [MIR_LENGTH_Reg-1:0]   CS_MIR_B_data_OutBUS,
  output logic [MIR_LENGTH_Reg-1:0]   CS_MIR_C_data_OutBUS,
  output logic                        CS_MIR_AMUX_data_Out,
  output logic                        CS_MIR_BMUX_data_Out,
  output logic                        CS_MIR_CMUX_data_Out,
  output logic                        CS_MIR_RD_data_Out,
  output logic                        CS_MIR_WR_data_Out,
  output logic [MIR_LENGTH_ALU-1:0]   CS_MIR_ALU_data_OutBUS,
  output logic [MIR_LENGTH_COND-1:0]  CS_MIR_COND_data_OutBUS,
  output logic [MIR_LENGTH_ADDR-1:0]  CS_MIR_ADDRESS_data_OutBUS,
  output logic                        CS_MIR_VALID_Out,
  output logic                        CS_MIR_STALL_Out,
  output logic [MIR_LENGTH_CNT-1:0]   CS_MIR_ISSUED_COUNT_OutBUS,
  output logic [1:0]                  o_state
);

  // Bit positions of each field, packed MSB to LSB as
  // A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, ADDR.
  localparam int P_ADDR = 0;
  localparam int P_COND = P_ADDR + MIR_LENGTH_ADDR;
  localparam int P_ALU  = P_COND + MIR_LENGTH_COND;
  localparam int P_WR   = P_ALU + MIR_LENGTH_ALU;
  localparam int P_RD   = P_WR + 1;
  localparam int P_CMUX = P_RD + 1;
  localparam int P_C    = P_CMUX + 1;
  localparam int P_BMUX = P_C + MIR_LENGTH_Reg;
  localparam int P_B    = P_BMUX + 1;
  localparam int P_AMUX = P_B + MIR_LENGTH_Reg;
  localparam int P_A    = P_AMUX + 1;

  localparam logic [3:0]                WAIT_INIT = 4'(MIR_MEM_WAIT);
  localparam bit                        HAS_WAIT  = (MIR_MEM_WAIT > 0);
  localparam logic [MIR_LENGTH_CNT-1:0] CNT_ONE   = MIR_LENGTH_CNT'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                      r_state;
  logic [MIR_LENGTH_INSTR-1:0] r_mir;
  logic [3:0]                  r_wait_cnt;
  logic [MIR_LENGTH_CNT-1:0]   r_issued;
  logic                        r_stall;
  logic                        r_valid;

  // RD and WR together still form one memory access, hence a single OR.
  logic w_mem_access;
  assign w_mem_access = CS_MIR_INSTRUCTION_data_InBUS[P_RD]
                      | CS_MIR_INSTRUCTION_data_InBUS[P_WR];

  always_ff @(posedge CS_MIR_CLOCK_50 or posedge CS_MIR_RESET_InHigh) begin
    if (CS_MIR_RESET_InHigh) begin
      r_mir      <= '0;
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_issued   <= '0;
      r_stall    <= 1'b0;
      r_valid    <= 1'b0;
    end else if (!CS_MIR_clear_InLow) begin
      // Clear aborts any wait and leaves a NOP; the issued count is history
      // and is deliberately kept.
      r_mir      <= '0;
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_stall    <= 1'b0;
      r_valid    <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      // Leaving on count==1 makes STALL high for exactly MIR_MEM_WAIT cycles.
      if (r_wait_cnt <= 4'd1) begin
        r_state    <= ST_EXEC;
        r_wait_cnt <= 4'd0;
        r_stall    <= 1'b0;
      end else begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end else if (!CS_MIR_load_InLow) begin
      r_mir   <= CS_MIR_INSTRUCTION_data_InBUS;
      r_valid <= 1'b1;
      if (r_issued != '1) begin
        r_issued <= r_issued + CNT_ONE;
      end
      if (w_mem_access && HAS_WAIT) begin
        r_state    <= ST_WAIT;
        r_wait_cnt <= WAIT_INIT;
        r_stall    <= 1'b1;
      end else begin
        r_state    <= ST_EXEC;
        r_wait_cnt <= 4'd0;
        r_stall    <= 1'b0;
      end
    end
  end

  assign CS_MIR_A_data_OutBUS       = r_mir[P_A +: MIR_LENGTH_Reg];
  assign CS_MIR_AMUX_data_Out       = r_mir[P_AMUX];
  assign CS_MIR_B_data_OutBUS       = r_mir[P_B +: MIR_LENGTH_Reg];
  assign CS_MIR_BMUX_data_Out       = r_mir[P_BMUX];
  assign CS_MIR_C_data_OutBUS       = r_mir[P_C +: MIR_LENGTH_Reg];
  assign CS_MIR_CMUX_data_Out       = r_mir[P_CMUX];
  assign CS_MIR_RD_data_Out         = r_mir[P_RD];
  assign CS_MIR_WR_data_Out         = r_mir[P_WR];
  assign CS_MIR_ALU_data_OutBUS     = r_mir[P_ALU +: MIR_LENGTH_ALU];
  assign CS_MIR_COND_data_OutBUS    = r_mir[P_COND +: MIR_LENGTH_COND];
  assign CS_MIR_ADDRESS_data_OutBUS = r_mir[P_ADDR +: MIR_LENGTH_ADDR];
  assign CS_MIR_VALID_Out           = r_valid;
  assign CS_MIR_STALL_Out           = r_stall;
  assign CS_MIR_ISSUED_COUNT_OutBUS = r_issued;
  assign o_state                    = r_state;

endmodule

// File: tb/tb_cs_mir_seq.sv
// -----------------------------------------------------------------------------
// tb_cs_mir_seq -- directed self-checking bench for cs_mir_seq
//
// dut  : default parameters (MIR_MEM_WAIT = 2, 16-bit counter)
// dut2 : MIR_LENGTH_CNT = 4, MIR_MEM_WAIT = 0 (saturation, no-wait case)
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_cs_mir_seq;

  localparam int IW = 41;

  logic clk;
  logic rst;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut signals
  logic          clear_n, load_n;
  logic [IW-1:0] instr;
  logic [5:0]    a_o, b_o, c_o;
  logic          amux_o, bmux_o, cmux_o, rd_o, wr_o, valid_o, stall_o;
  logic [3:0]    alu_o;
  logic [2:0]    cond_o;
  logic [10:0]   addr_o;
  logic [15:0]   cnt_o;
  logic [1:0]    state_o;

  // dut2 signals
  logic          clear2_n, load2_n;
  logic [IW-1:0] instr2;
  logic [5:0]    a2, b2, c2;
  logic          amux2, bmux2, cmux2, rd2, wr2, valid2, stall2;
  logic [3:0]    alu2;
  logic [2:0]    cond2;
  logic [10:0]   addr2;
  logic [3:0]    cnt2;
  logic [1:0]    state2;

  int n_checks = 0;
  int n_errors = 0;

  cs_mir_seq dut (
    .CS_MIR_CLOCK_50               (clk),
    .CS_MIR_RESET_InHigh           (rst),
    .CS_MIR_clear_InLow            (clear_n),
    .CS_MIR_load_InLow             (load_n),
    .CS_MIR_INSTRUCTION_data_InBUS (instr),
    .CS_MIR_A_data_OutBUS          (a_o),
    .CS_MIR_B_data_OutBUS          (b_o),
    .CS_MIR_C_data_OutBUS          (c_o),
    .CS_MIR_AMUX_data_Out          (amux_o),
    .CS_MIR_BMUX_data_Out          (bmux_o),
    .CS_MIR_CMUX_data_Out          (cmux_o),
    .CS_MIR_RD_data_Out            (rd_o),
    .CS_MIR_WR_data_Out            (wr_o),
    .CS_MIR_ALU_data_OutBUS        (alu_o),
    .CS_MIR_COND_data_OutBUS       (cond_o),
    .CS_MIR_ADDRESS_data_OutBUS    (addr_o),
    .CS_MIR_VALID_Out              (valid_o),
    .CS_MIR_STALL_Out              (stall_o),
    .CS_MIR_ISSUED_COUNT_OutBUS    (cnt_o),
    .o_state                       (state_o)
  );

  cs_mir_seq #(.MIR_MEM_WAIT(0), .MIR_LENGTH_CNT(4)) dut2 (
    .CS_MIR_CLOCK_50               (clk),
    .CS_MIR_RESET_InHigh           (rst),
    .CS_MIR_clear_InLow            (clear2_n),
    .CS_MIR_load_InLow             (load2_n),
    .CS_MIR_INSTRUCTION_data_InBUS (instr2),
    .CS_MIR_A_data_OutBUS          (a2),
    .CS_MIR_B_data_OutBUS          (b2),
    .CS_MIR_C_data_OutBUS          (c2),
    .CS_MIR_AMUX_data_Out          (amux2),
    .CS_MIR_BMUX_data_Out          (bmux2),
    .CS_MIR_CMUX_data_Out          (cmux2),
    .CS_MIR_RD_data_Out            (rd2),
    .CS_MIR_WR_data_Out            (wr2),
    .CS_MIR_ALU_data_OutBUS        (alu2),
    .CS_MIR_COND_data_OutBUS       (cond2),
    .CS_MIR_ADDRESS_data_OutBUS    (addr2),
    .CS_MIR_VALID_Out              (valid2),
    .CS_MIR_STALL_Out              (stall2),
    .CS_MIR_ISSUED_COUNT_OutBUS    (cnt2),
    .o_state                       (state2)
  );

  // Observed dut fields repacked in instruction order.
  logic [IW-1:0] obs;
  assign obs = {a_o, amux_o, b_o, bmux_o, c_o, cmux_o, rd_o, wr_o,
                alu_o, cond_o, addr_o};

  function automatic logic [IW-1:0] mk(
    input logic [5:0] a, input logic amux, input logic [5:0] b, input logic bmux,
    input logic [5:0] c, input logic cmux, input logic rd, input logic wr,
    input logic [3:0] alu, input logic [2:0] cond, input logic [10:0] addr);
    return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, addr};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    clear_n  = 1'b1;
    load_n   = 1'b1;
    instr    = '0;
    clear2_n = 1'b1;
    load2_n  = 1'b1;
    instr2   = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== '0) begin
      n_errors++; $display("FAIL reset_fields: got %h expected 0", obs);
    end
    n_checks++;
    if ({valid_o, stall_o} !== 2'b00) begin
      n_errors++; $display("FAIL reset_valid_stall: got %b expected 00", {valid_o, stall_o});
    end
    n_checks++;
    if (cnt_o !== 16'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", cnt_o);
    end
    n_checks++;
    if (state_o !== 2'd0) begin
      n_errors++; $display("FAIL reset_state: got %0d expected 0", state_o);
    end
  endtask

  task automatic test_load();
    do_reset();
    instr  = mk(6'd33, 1'b1, 6'd18, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 4'hA, 3'd5, 11'h3FF);
    load_n = 1'b0;
    tick();
    load_n = 1'b1;
    n_checks++;
    if ({a_o, b_o, c_o} !== {6'd33, 6'd18, 6'd7}) begin
      n_errors++; $display("FAIL load_abc: got %0d/%0d/%0d expected 33/18/7", a_o, b_o, c_o);
    end
    n_checks++;
    if ({amux_o, bmux_o, cmux_o, rd_o, wr_o} !== 5'b10100) begin
      n_errors++;
      $display("FAIL load_bits: got %b expected 10100", {amux_o, bmux_o, cmux_o, rd_o, wr_o});
    end
    n_checks++;
    if ({alu_o, cond_o, addr_o} !== {4'hA, 3'd5, 11'h3FF}) begin
      n_errors++;
      $display("FAIL load_alu_cond_addr: got %h/%0d/%h expected a/5/3ff", alu_o, cond_o, addr_o);
    end
    n_checks++;
    if ({valid_o, stall_o} !== 2'b10) begin
      n_errors++; $display("FAIL load_valid_stall: got %b expected 10", {valid_o, stall_o});
    end
    n_checks++;
    if (cnt_o !== 16'd1) begin
      n_errors++; $display("FAIL load_count: got %0d expected 1", cnt_o);
    end
    n_checks++;
    if (state_o !== 2'd1) begin
      n_errors++; $display("FAIL load_state: got %0d expected 1", state_o);
    end
  endtask

  task automatic test_hold();
    logic [IW-1:0] held;
    held = mk(6'd33, 1'b1, 6'd18, 1'b0, 6'd7, 1'b1, 1'b0, 1'b0, 4'hA, 3'd5, 11'h3FF);
    // Relies on test_load leaving 'held' in the register with count 1.
    instr  = mk(6'd1, 1'b0, 6'd2, 1'b1, 6'd3, 1'b0, 1'b1, 1'b1, 4'h1, 3'd1, 11'h001);
    load_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs !== held || cnt_o !== 16'd1 || valid_o !== 1'b1) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: got %h cnt %0d v %b expected %h cnt 1 v 1",
                 i, obs, cnt_o, valid_o, held);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [IW-1:0] i2, i3;
    logic [IW-1:0] exp_obs[4];
    logic          exp_stall[4];
    logic          exp_rd[4];
    logic [15:0]   exp_cnt[4];
    i2 = mk(6'd1, 1'b0, 6'd2, 1'b0, 6'd3, 1'b0, 1'b1, 1'b0, 4'h3, 3'd0, 11'h010);
    i3 = mk(6'd9, 1'b1, 6'd10, 1'b1, 6'd11, 1'b1, 1'b0, 1'b0, 4'h5, 3'd2, 11'h155);
    exp_obs   = '{i2, i2, i2, i3};
    exp_stall = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_rd    = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_cnt   = '{16'd1, 16'd1, 16'd1, 16'd2};
    do_reset();
    instr  = i2;
    load_n = 1'b0;
    tick();
    instr = i3;  // held with load low through the stall
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs !== exp_obs[k] || stall_o !== exp_stall[k] || rd_o !== exp_rd[k] ||
          cnt_o !== exp_cnt[k]) begin
        n_errors++;
        $display("FAIL mem_wait_cycle%0d: got %h st %b rd %b cnt %0d expected %h st %b rd %b cnt %0d",
                 k + 1, obs, stall_o, rd_o, cnt_o, exp_obs[k], exp_stall[k], exp_rd[k], exp_cnt[k]);
      end
    end
    load_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] i4, i5;
    logic [IW-1:0] exp_obs[6];
    logic          exp_stall[6];
    logic [15:0]   exp_cnt[6];
    // i4 has RD and WR both set: one wait period only.
    i4 = mk(6'd4, 1'b1, 6'd5, 1'b0, 6'd6, 1'b1, 1'b1, 1'b1, 4'h7, 3'd3, 11'h222);
    i5 = mk(6'd40, 1'b0, 6'd41, 1'b1, 6'd42, 1'b0, 1'b1, 1'b0, 4'hC, 3'd6, 11'h7FF);
    exp_obs   = '{i4, i4, i4, i5, i5, i5};
    exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_cnt   = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2};
    do_reset();
    instr  = i4;
    load_n = 1'b0;
    tick();
    instr = i5;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (obs !== exp_obs[k] || stall_o !== exp_stall[k] || cnt_o !== exp_cnt[k]) begin
        n_errors++;
        $display("FAIL back_to_back_cycle%0d: got %h st %b cnt %0d expected %h st %b cnt %0d",
                 k + 1, obs, stall_o, cnt_o, exp_obs[k], exp_stall[k], exp_cnt[k]);
      end
    end
    load_n = 1'b1;
  endtask

  task automatic test_clear();
    logic [IW-1:0] i_rd, i_n;
    i_rd = mk(6'd12, 1'b0, 6'd13, 1'b1, 6'd14, 1'b0, 1'b1, 1'b0, 4'h2, 3'd4, 11'h0AB);
    i_n  = mk(6'd20, 1'b1, 6'd21, 1'b0, 6'd22, 1'b1, 1'b0, 1'b0, 4'h9, 3'd7, 11'h300);
    do_reset();
    instr  = i_rd;
    load_n = 1'b0;
    tick();
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_errors++; $display("FAIL clear_pre_stall: got %b expected 1", stall_o);
    end
    clear_n = 1'b0;
    instr   = i_n;  // load stays low but clear wins
    tick();
    clear_n = 1'b1;
    n_checks++;
    if (obs !== '0 || valid_o !== 1'b0 || stall_o !== 1'b0 || cnt_o !== 16'd1) begin
      n_errors++;
      $display("FAIL clear_result: got %h v %b st %b cnt %0d expected 0 v 0 st 0 cnt 1",
               obs, valid_o, stall_o, cnt_o);
    end
    tick();
    load_n = 1'b1;
    n_checks++;
    if (obs !== i_n || valid_o !== 1'b1 || stall_o !== 1'b0 || cnt_o !== 16'd2) begin
      n_errors++;
      $display("FAIL clear_reload: got %h v %b st %b cnt %0d expected %h v 1 st 0 cnt 2",
               obs, valid_o, stall_o, cnt_o, i_n);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    instr  = mk(6'd63, 1'b1, 6'd62, 1'b1, 6'd61, 1'b1, 1'b0, 1'b1, 4'hF, 3'd7, 11'h555);
    load_n = 1'b0;
    tick();
    load_n = 1'b1;
    n_checks++;
    if (stall_o !== 1'b1 || cnt_o !== 16'd1) begin
      n_errors++; $display("FAIL async_pre: got st %b cnt %0d expected st 1 cnt 1", stall_o, cnt_o);
    end
    #2;  // between edges
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0 || valid_o !== 1'b0 || stall_o !== 1'b0 || cnt_o !== 16'd0 ||
        state_o !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: got %h v %b st %b cnt %0d s %0d expected all 0",
               obs, valid_o, stall_o, cnt_o, state_o);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_saturate_nowait();
    logic [3:0] exp_cnt;
    logic [IW-1:0] iw;
    do_reset();
    exp_cnt = 4'd0;
    iw      = mk(6'd3, 1'b0, 6'd3, 1'b0, 6'd3, 1'b0, 1'b0, 1'b1, 4'h4, 3'd1, 11'h077);
    instr2  = iw;
    load2_n = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      n_checks++;
      if (cnt2 !== exp_cnt || stall2 !== 1'b0 || wr2 !== 1'b1 || valid2 !== 1'b1) begin
        n_errors++;
        $display("FAIL saturate_load%0d: got cnt %0d st %b wr %b v %b expected cnt %0d st 0 wr 1 v 1",
                 i + 1, cnt2, stall2, wr2, valid2, exp_cnt);
      end
    end
    load2_n = 1'b1;
    n_checks++;
    if (cnt2 !== 4'hF) begin
      n_errors++; $display("FAIL saturate_final: got %h expected f", cnt2);
    end
  endtask

  initial begin
    rst = 1'b1; clear_n = 1'b1; load_n = 1'b1; instr = '0;
    clear2_n = 1'b1; load2_n = 1'b1; instr2 = '0;
    test_reset();
    test_load();
    test_hold();
    test_mem_wait();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_saturate_nowait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
